// File: rtl/nn_pkg.sv
// Shared neural-network layer package: activation selector, layer FSM states
// and the saturate/activation helpers used by every layer's MAC lanes.
package nn_pkg;

    typedef enum logic [1:0] {
        RELU,
        HARD_SIGMOID,
        NONE
    } activation_type;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        ACTIVATE,
        DONE
    } layer_state_t;

    // Wide enough for any accumulator of a 32-bit layer plus headroom, so the
    // helpers can be shared by layers of different word widths.
    localparam int NN_WIDE_W = 128;

    typedef logic signed [NN_WIDE_W-1:0] nn_wide_t;

    // Clamp a wide signed value into the range of a signed word of 'width' bits.
    function automatic nn_wide_t saturate(input nn_wide_t value, input int width);
        nn_wide_t hi;
        nn_wide_t lo;
        hi = (nn_wide_t'(1) <<< (width - 1)) - nn_wide_t'(1);
        lo = -(nn_wide_t'(1) <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Apply the selected activation to an already saturated fixed-point value.
    // Hard sigmoid is clamp(y/4 + 0.5, 0, 1.0) in the same fixed-point format.
    function automatic nn_wide_t activate(input nn_wide_t y, input activation_type act,
                                          input int frac_bits);
        nn_wide_t one;
        nn_wide_t half;
        nn_wide_t t;
        nn_wide_t r;
        one  = nn_wide_t'(1) <<< frac_bits;
        half = nn_wide_t'(1) <<< (frac_bits - 1);
        t    = (y >>> 2) + half;
        r    = y;
        case (act)
            RELU: begin
                r = (y < nn_wide_t'(0)) ? nn_wide_t'(0) : y;
            end
            HARD_SIGMOID: begin
                if (t < nn_wide_t'(0)) begin
                    r = nn_wide_t'(0);
                end else if (t > one) begin
                    r = one;
                end else begin
                    r = t;
                end
            end
            NONE: begin
                r = y;
            end
            default: begin
                r = y;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: accumulates input*weight products and the aligned bias,
// then produces the floor-shifted, saturated and activated output word.
module mac_lane
    import nn_pkg::*;
#(
    parameter int             DATA_WIDTH = 32,
    parameter int             FRAC_BITS  = 16,
    parameter int             NUM_INPUTS = 16,
    parameter activation_type ACTIVATION = RELU
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic                         mac_en_i,
    input  logic                         bias_en_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] w_i,
    output logic signed [DATA_WIDTH-1:0] result_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NUM_INPUTS + 1);

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  biasAligned;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    nn_wide_t                 accWide;
    nn_wide_t                 accShifted;

    // Next accumulator value: cleared per group, then products, then the bias
    // shifted up so it lines up with the 2*FRAC_BITS product scaling.
    always_comb begin
        product     = PROD_W'(x_i) * PROD_W'(w_i);
        biasAligned = ACC_W'(w_i) <<< FRAC_BITS;
        acc_d       = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + ACC_W'(product);
        end else if (bias_en_i) begin
            acc_d = acc_q + biasAligned;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Rescale to the word format (arithmetic shift floors), saturate, activate.
    always_comb begin
        accWide    = {{(NN_WIDE_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        accShifted = accWide >>> FRAC_BITS;
        result_o   = DATA_WIDTH'(activate(saturate(accShifted, DATA_WIDTH), ACTIVATION, FRAC_BITS));
    end

endmodule

// File: rtl/folded_dense_layer.sv
// Time-multiplexed dense layer: NUM_LANES MAC lanes evaluate the neurons one
// group at a time, streaming weights and biases from an external memory.
module folded_dense_layer
    import nn_pkg::*;
#(
    parameter int             DATA_WIDTH  = 32,
    parameter int             FRAC_BITS   = 16,
    parameter int             NUM_INPUTS  = 16,
    parameter int             NUM_NEURONS = 16,
    parameter int             NUM_LANES   = 4,
    parameter activation_type ACTIVATION  = RELU,
    localparam int            NUM_GROUPS  = NUM_NEURONS / NUM_LANES,
    localparam int            ADDR_W      = ((NUM_GROUPS * (NUM_INPUTS + 1)) > 1) ?
                                            $clog2(NUM_GROUPS * (NUM_INPUTS + 1)) : 1
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   inputs_valid_i,
    output logic                                   inputs_ready_o,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs_i,
    output logic                                   weight_read_o,
    output logic [ADDR_W-1:0]                      weight_address_o,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   weight_data_i,
    output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] outputs_o,
    output logic                                   outputs_valid_o,
    input  logic                                   outputs_ready_i
);

    localparam int GROUP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int INDEX_W = $clog2(NUM_INPUTS + 1);
    localparam int STRIDE  = NUM_INPUTS + 1;

    layer_state_t                          state_q;
    logic [GROUP_W-1:0]                    group_q;
    logic [INDEX_W-1:0]                    index_q;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputVector_q;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] outputBank_q;
    logic                                  read_q;
    logic [ADDR_W-1:0]                     address_q;
    logic                                  valid_q;

    logic [DATA_WIDTH-1:0]                 xSelect;
    logic                                  laneClear;
    logic                                  laneMac;
    logic                                  laneBias;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  laneResult;

    function automatic logic [ADDR_W-1:0] addrOf(input int grp, input int index);
        return ADDR_W'(grp * STRIDE + index);
    endfunction

    // Pick the input word matching the weight index being consumed this cycle.
    always_comb begin
        xSelect = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (index_q == INDEX_W'(i)) begin
                xSelect = inputVector_q[i];
            end
        end
    end

    // Lane strobes decoded from the state and the weight index.
    always_comb begin
        laneClear = (state_q == FETCH);
        laneMac   = (state_q == MAC) && (index_q != INDEX_W'(NUM_INPUTS));
        laneBias  = (state_q == MAC) && (index_q == INDEX_W'(NUM_INPUTS));
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .NUM_INPUTS (NUM_INPUTS),
            .ACTIVATION (ACTIVATION)
        ) uLane (
            .clock_i   (clock_i),
            .reset_i   (reset_i),
            .clear_i   (laneClear),
            .mac_en_i  (laneMac),
            .bias_en_i (laneBias),
            .x_i       (xSelect),
            .w_i       (weight_data_i[l]),
            .result_o  (laneResult[l])
        );
    end

    // Layer controller: sequences groups, issues weight reads one index ahead
    // of consumption and commits each finished group into the output bank.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            group_q       <= '0;
            index_q       <= '0;
            inputVector_q <= '0;
            outputBank_q  <= '0;
            read_q        <= 1'b0;
            address_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inputs_valid_i) begin
                        inputVector_q <= inputs_i;
                        group_q       <= '0;
                        index_q       <= '0;
                        read_q        <= 1'b1;
                        address_q     <= addrOf(0, 0);
                        state_q       <= FETCH;
                    end
                end
                FETCH: begin
                    index_q   <= '0;
                    read_q    <= 1'b1;
                    address_q <= addrOf(int'(group_q), 1);
                    state_q   <= MAC;
                end
                MAC: begin
                    if (index_q == INDEX_W'(NUM_INPUTS)) begin
                        read_q  <= 1'b0;
                        state_q <= ACTIVATE;
                    end else begin
                        index_q <= index_q + INDEX_W'(1);
                        if ((int'(index_q) + 2) <= NUM_INPUTS) begin
                            read_q    <= 1'b1;
                            address_q <= addrOf(int'(group_q), int'(index_q) + 2);
                        end else begin
                            read_q <= 1'b0;
                        end
                    end
                end
                ACTIVATE: begin
                    for (int g = 0; g < NUM_GROUPS; g++) begin
                        if (group_q == GROUP_W'(g)) begin
                            for (int l = 0; l < NUM_LANES; l++) begin
                                outputBank_q[g * NUM_LANES + l] <= laneResult[l];
                            end
                        end
                    end
                    if (group_q == GROUP_W'(NUM_GROUPS - 1)) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        group_q   <= group_q + GROUP_W'(1);
                        read_q    <= 1'b1;
                        address_q <= addrOf(int'(group_q) + 1, 0);
                        state_q   <= FETCH;
                    end
                end
                DONE: begin
                    if (outputs_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inputs_ready_o   = (state_q == IDLE);
    assign weight_read_o    = read_q;
    assign weight_address_o = address_q;
    assign outputs_o        = outputBank_q;
    assign outputs_valid_o  = valid_q;

endmodule
